usb_host_txn_ctrl: RTL
======================

Name: usb_host_txn_ctrl

Overview:
- Host-side USB transaction sequencer; sits above the packet-level FSMs: token send, data send, handshake send, receive_data and receive_acknak.
- For each requested OUT or IN transaction it issues start pulses to those FSMs in protocol order and collects their done/success/fail results.
- Retries NAKed, timed-out or corrupted transactions up to a limit.
- Reports one completion pulse per transaction to the top-level controller.

Parameters:
- MAX_ATTEMPTS, 3, total transaction attempts before failure (legal 1..15).
- WDOG_CYC, 1023, max cycles spent in any single wait state before abort (legal 16..65535).

Ports:
- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- txn_start  in  1  pulse; request a transaction (accepted only in IDLE)
- txn_read  in  1  sampled with txn_start; 1=IN, 0=OUT
- busy  out  1  high whenever state != IDLE
- txn_done  out  1  one-cycle completion pulse
- txn_success  out  1  valid with txn_done; 1=ACKed/data good
- txn_abort  out  1  valid with txn_done; 1=watchdog expiry
- attempt_cnt  out  4  attempts used in current/last transaction
- tok_start  out  1  pulse; send token packet
- tok_pid  out  4  0001 (OUT) or 1001 (IN), held stable while busy
- tok_done  in  1  pulse; token sent
- dat_start  out  1  pulse; send DATA0 packet
- dat_done  in  1  pulse; data packet sent
- hs_start  out  1  pulse; send handshake packet
- hs_pid  out  4  0010 (ACK) or 1010 (NAK), stable from hs_start until hs_done
- hs_done  in  1  pulse; handshake sent
- rd_start  out  1  pulse; start receive_data
- rd_done  in  1  pulse; receive_data finished
- rd_success  in  1  valid with rd_done; CRC good
- rd_fail  in  1  pulse; receive_data sync timeout
- ra_start  out  1  pulse; start receive_acknak
- ra_ack  in  1  pulse; ACK received
- ra_nak  in  1  pulse; NAK received
- ra_fail  in  1  pulse; receive_acknak timeout

Behaviour:
- **Reset:** state IDLE. All outputs 0, including attempt_cnt, tok_pid and hs_pid. Reset mid-transaction abandons it silently; no txn_done is produced.
- **Registered outputs:** all outputs are registered. Each *_start pulse is high for exactly the first cycle of the state it launches.
- **States:** IDLE, TOKEN, OUT_DATA, OUT_HS, IN_DATA, IN_HS, RETRY, DONE.
- **IDLE:**
  - txn_start=1 latches txn_read, sets tok_pid, sets attempt_cnt=1, goes to TOKEN.
  - txn_start while busy is ignored.
- **TOKEN:** tok_start pulse. On tok_done: txn_read=0 goes to OUT_DATA; txn_read=1 goes to IN_DATA.
- **OUT_DATA:** dat_start pulse. On dat_done goes to OUT_HS.
- **OUT_HS:** ra_start pulse.
  - ra_ack alone goes to DONE with success=1.
  - ra_nak, ra_fail, or ra_ack and ra_nak together go to RETRY.
- **IN_DATA:** rd_start pulse.
  - rd_fail goes to RETRY.
  - rd_done with rd_success=1: hs_pid=ACK, go to IN_HS.
  - rd_done with rd_success=0: hs_pid=NAK, go to IN_HS.
  - rd_fail and rd_done in the same cycle: rd_fail wins.
- **IN_HS:** hs_start pulse. On hs_done: hs_pid=ACK goes to DONE with success=1; hs_pid=NAK goes to RETRY.
- **RETRY (1 cycle):**
  - attempt_cnt==MAX_ATTEMPTS goes to DONE with success=0.
  - Otherwise attempt_cnt+1 and go to TOKEN.
- **DONE (1 cycle):** txn_done=1 with txn_success/txn_abort. Next state IDLE. attempt_cnt holds until the next accepted txn_start.
- **Stray handshakes:** done/ack/nak/fail inputs arriving outside their owning state are ignored.
- **Watchdog:** 16-bit counter cleared on every state entry and incremented each cycle in TOKEN, OUT_DATA, OUT_HS, IN_DATA and IN_HS.
  - Reaching WDOG_CYC-1 without a qualifying input goes to DONE with success=0, abort=1. No retry.
  - A qualifying input in the expiry cycle takes precedence over the abort.
- **Latency:** txn_start to tok_start is 1 cycle. Any qualifying done to the next *_start is 1 cycle.

Test Plan:
- OUT, clean: txn_start, txn_read=0. Expect tok_pid=0001 and tok_start 1 cycle later. Answer tok_done, dat_done, ra_ack. Expect txn_done=1, success=1, attempt_cnt=1; busy low the next cycle.
- OUT, NAK then ACK (MAX_ATTEMPTS=3): answer ra_nak, then ra_ack. Expect tok_start twice, txn_done with success=1, attempt_cnt=2.
- IN, CRC error then good: first rd_done with rd_success=0 produces hs_pid=1010 (NAK). Second produces hs_pid=0010 (ACK). Expect success=1, attempt_cnt=2.
- Retry exhaustion: three consecutive rd_fail pulses. Expect exactly 3 tok_start pulses, no hs_start, txn_done with success=0, abort=0, attempt_cnt=3.
- Watchdog (WDOG_CYC=16): withhold dat_done. Expect txn_done with success=0, abort=1, 16 cycles after OUT_DATA entry.
- Robustness:
  - Inject stray ra_ack while in IDLE, and txn_start while busy: no state change.
  - Assert rst_l=0 in OUT_HS: all outputs 0 immediately, no txn_done.

Source files
------------

// File: rtl/usb_host_txn_ctrl_if.sv
// Transaction request/completion and packet-FSM start/done signals of the host transaction sequencer.
// master = sequencer side, slave = top-level controller plus packet FSMs.
interface usb_host_txn_ctrl_if;
  logic       txn_start;
  logic       txn_read;
  logic       busy;
  logic       txn_done;
  logic       txn_success;
  logic       txn_abort;
  logic [3:0] attempt_cnt;
  logic       tok_start;
  logic [3:0] tok_pid;
  logic       tok_done;
  logic       dat_start;
  logic       dat_done;
  logic       hs_start;
  logic [3:0] hs_pid;
  logic       hs_done;
  logic       rd_start;
  logic       rd_done;
  logic       rd_success;
  logic       rd_fail;
  logic       ra_start;
  logic       ra_ack;
  logic       ra_nak;
  logic       ra_fail;

  modport master (
    input  txn_start, txn_read, tok_done, dat_done, hs_done,
           rd_done, rd_success, rd_fail, ra_ack, ra_nak, ra_fail,
    output busy, txn_done, txn_success, txn_abort, attempt_cnt,
           tok_start, tok_pid, dat_start, hs_start, hs_pid, rd_start, ra_start
  );

  modport slave (
    output txn_start, txn_read, tok_done, dat_done, hs_done,
           rd_done, rd_success, rd_fail, ra_ack, ra_nak, ra_fail,
    input  busy, txn_done, txn_success, txn_abort, attempt_cnt,
           tok_start, tok_pid, dat_start, hs_start, hs_pid, rd_start, ra_start
  );
endinterface

// File: rtl/usb_host_txn_ctrl.sv
// Host USB transaction sequencer: drives token/data/handshake packet FSMs, retries, watchdog.
// All outputs registered; start pulses occupy the first cycle of the state they launch.
module usb_host_txn_ctrl #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int WDOG_CYC     = 1023
) (
  input  logic                 clk,
  input  logic                 rst_l,
  usb_host_txn_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TOKEN    = 3'd1;
  localparam logic [2:0] S_OUT_DATA = 3'd2;
  localparam logic [2:0] S_OUT_HS   = 3'd3;
  localparam logic [2:0] S_IN_DATA  = 3'd4;
  localparam logic [2:0] S_IN_HS    = 3'd5;
  localparam logic [2:0] S_RETRY    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;

  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);
  localparam logic [3:0]  ATT_MAX   = 4'(MAX_ATTEMPTS);

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [15:0] wdog;
  logic        txn_rd;
  logic        wd_exp;
  logic        entering;
  logic        waiting;
  logic        end_ok;
  logic        end_abort;

  assign wd_exp   = (wdog == WDOG_LAST);
  assign entering = (nxt != state);
  assign waiting  = (state == S_TOKEN) || (state == S_OUT_DATA) || (state == S_OUT_HS) ||
                    (state == S_IN_DATA) || (state == S_IN_HS);

  // Qualifying inputs are tested before the watchdog so a late answer still wins.
  always_comb begin
    nxt       = state;
    end_ok    = 1'b0;
    end_abort = 1'b0;
    case (state)
      S_IDLE:     if (bus.txn_start) nxt = S_TOKEN;
      S_TOKEN: begin
        if (bus.tok_done)  nxt = txn_rd ? S_IN_DATA : S_OUT_DATA;
        else if (wd_exp) begin nxt = S_DONE; end_abort = 1'b1; end
      end
      S_OUT_DATA: begin
        if (bus.dat_done)  nxt = S_OUT_HS;
        else if (wd_exp) begin nxt = S_DONE; end_abort = 1'b1; end
      end
      S_OUT_HS: begin
        if (bus.ra_nak || bus.ra_fail) nxt = S_RETRY;
        else if (bus.ra_ack) begin nxt = S_DONE; end_ok = 1'b1; end
        else if (wd_exp)     begin nxt = S_DONE; end_abort = 1'b1; end
      end
      S_IN_DATA: begin
        if (bus.rd_fail)       nxt = S_RETRY;
        else if (bus.rd_done)  nxt = S_IN_HS;
        else if (wd_exp) begin nxt = S_DONE; end_abort = 1'b1; end
      end
      S_IN_HS: begin
        if (bus.hs_done) begin
          if (bus.hs_pid == PID_ACK) begin nxt = S_DONE; end_ok = 1'b1; end
          else nxt = S_RETRY;
        end else if (wd_exp) begin nxt = S_DONE; end_abort = 1'b1; end
      end
      S_RETRY:    nxt = (bus.attempt_cnt == ATT_MAX) ? S_DONE : S_TOKEN;
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= S_IDLE;
      wdog            <= '0;
      txn_rd          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.txn_done    <= 1'b0;
      bus.txn_success <= 1'b0;
      bus.txn_abort   <= 1'b0;
      bus.attempt_cnt <= '0;
      bus.tok_start   <= 1'b0;
      bus.tok_pid     <= '0;
      bus.dat_start   <= 1'b0;
      bus.hs_start    <= 1'b0;
      bus.hs_pid      <= '0;
      bus.rd_start    <= 1'b0;
      bus.ra_start    <= 1'b0;
    end else begin
      state           <= nxt;
      bus.busy        <= (nxt != S_IDLE);
      bus.tok_start   <= entering && (nxt == S_TOKEN);
      bus.dat_start   <= entering && (nxt == S_OUT_DATA);
      bus.ra_start    <= entering && (nxt == S_OUT_HS);
      bus.rd_start    <= entering && (nxt == S_IN_DATA);
      bus.hs_start    <= entering && (nxt == S_IN_HS);
      bus.txn_done    <= entering && (nxt == S_DONE);
      bus.txn_success <= entering && (nxt == S_DONE) && end_ok;
      bus.txn_abort   <= entering && (nxt == S_DONE) && end_abort;

      if (entering)     wdog <= '0;
      else if (waiting) wdog <= wdog + 16'd1;

      if (state == S_IDLE && bus.txn_start) begin
        txn_rd          <= bus.txn_read;
        bus.tok_pid     <= bus.txn_read ? PID_IN : PID_OUT;
        bus.attempt_cnt <= 4'd1;
      end
      if (state == S_RETRY && nxt == S_TOKEN)
        bus.attempt_cnt <= bus.attempt_cnt + 4'd1;
      if (state == S_IN_DATA && bus.rd_done && !bus.rd_fail)
        bus.hs_pid <= bus.rd_success ? PID_ACK : PID_NAK;
    end
  end

endmodule
